mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Consumer of the EX/MEM pipeline register in the 20-bit MIPS core. Takes the latched EX bundle,
//  performs at most one data-memory access over a req/ready handshake, and resolves branch/jump/jmem
//  redirects. Stalls upstream while an access is outstanding and loads the MEM/WB register
//  (wb_* outputs) feeding write-back.
// PARAMETERS
//  DATA_W        20   datapath and address width
//  TIMEOUT_CYCLES 255 max cycles in REQ without dmem_ready before abort (>=1)
// PORTS
//  clk                  in   1       rising-edge clock, sole clock domain
//  rst                  in   1       synchronous, active-high reset
//  ex_valid             in   1       EX/MEM bundle holds a real instruction (0 = bubble)
//  ex_write_destination in   DATA_W  destination register index
//  ex_zero_flaf         in   1       ALU zero flag
//  ex_alu_output        in   DATA_W  ALU result / memory address
//  ex_result_shift_jump in   DATA_W  jump target
//  ex_result_adder_branch in DATA_W  branch target
//  ex_read_data2        in   DATA_W  store data
//  ex_output_adder_increment_pc in DATA_W  PC+1
//  ex_memwrite, ex_memread, ex_branch, ex_j, ex_jmem, ex_stw, ex_regwrite  in 1 each  control
//  stall                out  1       hold EX/MEM and earlier stages (combinational)
//  dmem_req             out  1       memory request, held until dmem_ready or timeout
//  dmem_we              out  1       1 = write
//  dmem_addr            out  DATA_W  access address
//  dmem_wdata           out  DATA_W  write data
//  dmem_rdata           in   DATA_W  read data, valid with dmem_ready
//  dmem_ready           in   1       access completes this cycle
//  pc_redirect          out  1       1-cycle pulse: fetch must load pc_target
//  pc_target            out  DATA_W  redirect address
//  wb_valid             out  1       MEM/WB holds a retired instruction (1-cycle per instruction)
//  wb_regwrite          out  1       register-file write enable
//  wb_write_destination out  DATA_W  destination index
//  wb_data              out  DATA_W  write-back value
//  mem_err              out  1       1-cycle pulse on access timeout
// BEHAVIOUR
//  - Reset: state IDLE; every registered output 0; counter 0. Reset mid-access abandons it:
//    dmem_req low after the reset edge, no writeback, no redirect, no mem_err.
//  - is_mem = memread|memwrite|stw|jmem. One access per instruction; priority jmem > memread > stw > memwrite.
//    read for jmem/memread at alu_output; stw writes output_adder_increment_pc, memwrite writes read_data2,
//    both at alu_output.
//  - IDLE, ex_valid & !is_mem: retires at next edge (latency 1): wb_* loaded, wb_data = alu_output.
//  - IDLE, ex_valid & is_mem: latch bundle; -> REQ; dmem_req/we/addr/wdata registered, high from next cycle.
//  - REQ: counter increments each cycle; on dmem_ready -> IDLE and retire at that edge;
//    wb_data = dmem_rdata if memread else alu_output.
//  - stall = (IDLE & ex_valid & is_mem) | (REQ & !dmem_ready); EX/MEM advances on the completing edge, so
//    back-to-back memory ops lose no cycle beyond the accept cycle.
//  - Redirect (registered, with retire): jmem -> dmem_rdata; else j -> result_shift_jump;
//    else branch & zero_flaf -> result_adder_branch. Otherwise pc_redirect = 0.
//  - Timeout: counter reaches TIMEOUT_CYCLES without ready -> drop dmem_req, -> IDLE, mem_err pulse,
//    wb_valid=1 with wb_regwrite=0, no redirect. dmem_ready arriving on the timeout cycle wins.
//  - ex_valid=0: bubble; wb_valid, wb_regwrite, pc_redirect 0 next cycle.
//  - dmem_ready outside REQ is ignored.
// STRUCTURE
//  - mips20_pkg: DATA_W, state encoding {IDLE, REQ}, access-kind encoding, redirect-priority constants.
//  - One sub-module: mem_wb_reg (MEM/WB register: wb_* outputs, sync reset, load enable).
//  - FSM, access select, redirect mux and timeout counter stay in mem_access_stage.
// TESTING
//  - ALU op: alu_output=0x00ABC, regwrite, dest=5 -> next cycle wb_valid=1, wb_data=0x00ABC, stall never high.
//  - Load, ready after 3 cycles, rdata=0x12345 -> stall 4 cycles, dmem_we=0, wb_data=0x12345, dest written once.
//  - stw at 0x00100, PC+1=0x00041 -> dmem_we=1, wdata=0x00041; wb_regwrite=0, no redirect.
//  - jmem with rdata=0x00200 -> pc_redirect pulse, pc_target=0x00200; j+branch both set -> j target used.
//  - TIMEOUT_CYCLES=4, ready never asserted -> dmem_req drops after 4 REQ cycles, mem_err=1, wb_regwrite=0.
//  - rst in 2nd REQ cycle -> all outputs 0 next cycle, stall 0, no wb_valid, following load completes normally.

Source files
------------

// File: rtl/mips20_pkg.sv
// Shared widths, FSM encoding and access/redirect selection helpers for the
// 20-bit MIPS memory-access stage.
package mips20_pkg;

   localparam int DATA_W = 20;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   typedef enum logic [1:0] {
      ACC_STORE = 2'd0,
      ACC_STW   = 2'd1,
      ACC_LOAD  = 2'd2,
      ACC_JMEM  = 2'd3
   } acc_kind_e;

   // Encoded so that a higher value means a higher redirect priority.
   typedef enum logic [1:0] {
      REDIR_NONE   = 2'd0,
      REDIR_BRANCH = 2'd1,
      REDIR_JUMP   = 2'd2,
      REDIR_JMEM   = 2'd3
   } redir_sel_e;

   // Fields of the EX/MEM bundle still needed once an access is in flight.
   typedef struct packed {
      logic [DATA_W-1:0] write_destination;
      logic [DATA_W-1:0] alu_output;
      logic [DATA_W-1:0] result_shift_jump;
      logic [DATA_W-1:0] result_adder_branch;
      logic              memread;
      logic              regwrite;
      logic              j;
      logic              jmem;
      logic              branch;
      logic              zero_flaf;
   } lat_bundle_t;

   function automatic acc_kind_e acc_kind(input logic jmem, input logic memread,
                                          input logic stw);
      if (jmem)         return ACC_JMEM;
      else if (memread) return ACC_LOAD;
      else if (stw)     return ACC_STW;
      else              return ACC_STORE;
   endfunction

   function automatic redir_sel_e redir_sel(input logic jmem, input logic j,
                                            input logic branch, input logic zero_flaf);
      if (jmem)                     return REDIR_JMEM;
      else if (j)                   return REDIR_JUMP;
      else if (branch && zero_flaf) return REDIR_BRANCH;
      else                          return REDIR_NONE;
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. Valid and regwrite are single-cycle per load;
// destination and data hold their last retired value.
module mem_wb_reg
   import mips20_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              in_regwrite,
   input  logic [DATA_W-1:0] in_write_destination,
   input  logic [DATA_W-1:0] in_data,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [DATA_W-1:0] wb_write_destination,
   output logic [DATA_W-1:0] wb_data
);

   logic              valid_q, valid_d;
   logic              regwrite_q, regwrite_d;
   logic [DATA_W-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d    = load;
      regwrite_d = load & in_regwrite;
      dest_d     = load ? in_write_destination : dest_q;
      data_d     = load ? in_data : data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         dest_q     <= '0;
         data_q     <= '0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         dest_q     <= dest_d;
         data_q     <= data_d;
      end
   end

   assign wb_valid             = valid_q;
   assign wb_regwrite          = regwrite_q;
   assign wb_write_destination = dest_q;
   assign wb_data              = data_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 20-bit MIPS core: one data-memory access per instruction over
// req/ready, branch/jump/jmem redirect resolution, stall generation and MEM/WB load.
module mem_access_stage
   import mips20_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_write_destination,
   input  logic              ex_zero_flaf,
   input  logic [DATA_W-1:0] ex_alu_output,
   input  logic [DATA_W-1:0] ex_result_shift_jump,
   input  logic [DATA_W-1:0] ex_result_adder_branch,
   input  logic [DATA_W-1:0] ex_read_data2,
   input  logic [DATA_W-1:0] ex_output_adder_increment_pc,
   input  logic              ex_memwrite,
   input  logic              ex_memread,
   input  logic              ex_branch,
   input  logic              ex_j,
   input  logic              ex_jmem,
   input  logic              ex_stw,
   input  logic              ex_regwrite,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              pc_redirect,
   output logic [DATA_W-1:0] pc_target,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [DATA_W-1:0] wb_write_destination,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // Handshake: dmem_req rises the cycle after accept and stays high, with
   // we/addr/wdata stable, until the cycle dmem_ready is seen or the timeout fires.
   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   lat_bundle_t       lat_q, lat_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              redirect_q, redirect_d;
   logic [DATA_W-1:0] target_q, target_d;
   logic              err_q, err_d;

   lat_bundle_t       ex_bundle;
   logic              is_mem;
   logic              timeout_hit;
   acc_kind_e         kind;
   redir_sel_e        rsel;
   logic [DATA_W-1:0] redir_addr;
   logic              retire;
   logic              rt_regwrite;
   logic [DATA_W-1:0] rt_dest;
   logic [DATA_W-1:0] rt_data;

   always_comb begin
      ex_bundle.write_destination   = ex_write_destination;
      ex_bundle.alu_output          = ex_alu_output;
      ex_bundle.result_shift_jump   = ex_result_shift_jump;
      ex_bundle.result_adder_branch = ex_result_adder_branch;
      ex_bundle.memread             = ex_memread;
      ex_bundle.regwrite            = ex_regwrite;
      ex_bundle.j                   = ex_j;
      ex_bundle.jmem                = ex_jmem;
      ex_bundle.branch              = ex_branch;
      ex_bundle.zero_flaf           = ex_zero_flaf;
   end

   assign is_mem      = ex_memread | ex_memwrite | ex_stw | ex_jmem;
   assign kind        = acc_kind(ex_jmem, ex_memread, ex_stw);
   assign timeout_hit = (state_q == ST_REQ) && !dmem_ready && (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_d       = lat_q;
      req_d       = req_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = 1'b0;
      stall       = 1'b0;
      retire      = 1'b0;
      rt_regwrite = 1'b0;
      rt_dest     = ex_write_destination;
      rt_data     = ex_alu_output;
      rsel        = REDIR_NONE;

      case (state_q)
         ST_IDLE: begin
            if (ex_valid && is_mem) begin
               stall   = 1'b1;
               lat_d   = ex_bundle;
               state_d = ST_REQ;
               cnt_d   = '0;
               req_d   = 1'b1;
               we_d    = (kind == ACC_STW) || (kind == ACC_STORE);
               addr_d  = ex_alu_output;
               wdata_d = (kind == ACC_STW) ? ex_output_adder_increment_pc : ex_read_data2;
            end else if (ex_valid) begin
               retire      = 1'b1;
               rt_regwrite = ex_regwrite;
               rsel        = redir_sel(1'b0, ex_j, ex_branch, ex_zero_flaf);
            end
         end
         ST_REQ: begin
            cnt_d   = cnt_q + CNT_W'(1);
            rt_dest = lat_q.write_destination;
            rt_data = lat_q.alu_output;
            if (dmem_ready) begin
               state_d     = ST_IDLE;
               req_d       = 1'b0;
               retire      = 1'b1;
               rt_regwrite = lat_q.regwrite;
               rt_data     = lat_q.memread ? dmem_rdata : lat_q.alu_output;
               rsel        = redir_sel(lat_q.jmem, lat_q.j, lat_q.branch, lat_q.zero_flaf);
            end else if (timeout_hit) begin
               // The aborted instruction retires too, so EX/MEM must advance
               // here or the same access would simply be issued again.
               state_d = ST_IDLE;
               req_d   = 1'b0;
               retire  = 1'b1;
               err_d   = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_comb begin
      case (rsel)
         REDIR_JMEM:   redir_addr = dmem_rdata;
         REDIR_JUMP:   redir_addr = (state_q == ST_REQ) ? lat_q.result_shift_jump
                                                        : ex_result_shift_jump;
         REDIR_BRANCH: redir_addr = (state_q == ST_REQ) ? lat_q.result_adder_branch
                                                        : ex_result_adder_branch;
         default:      redir_addr = target_q;
      endcase
      redirect_d = retire && (rsel != REDIR_NONE);
      target_d   = redirect_d ? redir_addr : target_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lat_q      <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         redirect_q <= 1'b0;
         target_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lat_q      <= lat_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
         err_q      <= err_d;
      end
   end

   mem_wb_reg u_mem_wb_reg (
      .clk                  (clk),
      .rst                  (rst),
      .load                 (retire),
      .in_regwrite          (rt_regwrite),
      .in_write_destination (rt_dest),
      .in_data              (rt_data),
      .wb_valid             (wb_valid),
      .wb_regwrite          (wb_regwrite),
      .wb_write_destination (wb_write_destination),
      .wb_data              (wb_data)
   );

   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_wdata  = wdata_q;
   assign pc_redirect = redirect_q;
   assign pc_target   = target_q;
   assign mem_err     = err_q;

endmodule
